// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, flag bit positions and result-stage sizing.
package cpu_pkg;

    typedef enum logic [2:0] {
        COND_AL = 3'b000,
        COND_EQ = 3'b001,
        COND_NE = 3'b010,
        COND_LT = 3'b011,
        COND_GE = 3'b100,
        COND_GT = 3'b101,
        COND_LE = 3'b110,
        COND_NV = 3'b111
    } cond_e;

    localparam int unsigned FLAG_N     = 3;
    localparam int unsigned FLAG_Z     = 2;
    localparam int unsigned FLAG_C     = 1;
    localparam int unsigned FLAG_V     = 0;
    localparam int unsigned FLAGS_W    = 4;
    localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/cond_check.sv
// Combinational condition-code evaluation against a {N,Z,C,V} flag word.
module cond_check
    import cpu_pkg::*;
(
    input  logic [FLAGS_W-1:0] flags,
    input  logic [2:0]         cond,
    output logic               pass
);

    logic n;
    logic z;
    logic v;
    logic unused_c;

    assign n        = flags[FLAG_N];
    assign z        = flags[FLAG_Z];
    assign v        = flags[FLAG_V];
    assign unused_c = flags[FLAG_C];

    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            COND_AL: pass = 1'b1;
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_LT: pass = (n != v);
            COND_GE: pass = (n == v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: predicated commit of flags and a 2-entry in-order result FIFO
// toward the register-file write port.
module alu_result_stage
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RW    = 4
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_result,
    input  logic [FLAGS_W-1:0] in_flags,
    input  logic [RW-1:0]      in_rd,
    input  logic [2:0]         in_cond,
    input  logic               in_reg_write,
    input  logic               in_flag_set,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic [RW-1:0]      out_rd,
    output logic               out_we,
    output logic [FLAGS_W-1:0] flags_q
);

    logic [1:0]         count_q;
    logic [1:0]         count_d;
    logic               wr_ptr_q;
    logic               wr_ptr_d;
    logic               rd_ptr_q;
    logic               rd_ptr_d;
    logic               arm_q;
    logic               arm_d;
    logic [FLAGS_W-1:0] flags_d;

    logic [WIDTH-1:0]   result_mem_q [FIFO_DEPTH];
    logic [RW-1:0]      rd_mem_q     [FIFO_DEPTH];
    logic               we_mem_q     [FIFO_DEPTH];

    logic               cond_pass;
    logic               accept;
    logic               push;
    logic               pop;

    // Predicate uses the committed flag register only, never the incoming flags.
    cond_check u_cond_check (
        .flags (flags_q),
        .cond  (in_cond),
        .pass  (cond_pass)
    );

    // arm_q keeps in_ready low until the first edge after reset release.
    assign in_ready   = arm_q && (count_q != 2'(FIFO_DEPTH));
    assign out_valid  = (count_q != 2'd0);
    assign out_result = result_mem_q[rd_ptr_q];
    assign out_rd     = rd_mem_q[rd_ptr_q];
    assign out_we     = we_mem_q[rd_ptr_q];

    assign accept = in_valid && in_ready;
    assign push   = accept && cond_pass && !flush;
    assign pop    = out_valid && out_ready;

    always_comb begin
        arm_d    = 1'b1;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        flags_d  = flags_q;

        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
            if (push && in_flag_set) begin
                flags_d = in_flags;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_q    <= 1'b0;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            flags_q  <= '0;
        end else begin
            arm_q    <= arm_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            flags_q  <= flags_d;
        end
    end

    // Payload storage is not reset; contents are ignored while out_valid is low.
    always_ff @(posedge clk) begin
        if (push) begin
            result_mem_q[wr_ptr_q] <= in_result;
            rd_mem_q[wr_ptr_q]     <= in_rd;
            we_mem_q[wr_ptr_q]     <= in_reg_write;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
module tb_alu_result_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [3:0]  in_flags;
    logic [3:0]  in_rd;
    logic [2:0]  in_cond;
    logic        in_reg_write;
    logic        in_flag_set;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_rd;
    logic        out_we;
    logic [3:0]  flags_q;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Condition table: flags to load, condition code, expected pass.
    localparam logic [3:0] CF [11] = '{4'b0100, 4'b0000, 4'b0100, 4'b1000, 4'b1001, 4'b1001,
                                       4'b0000, 4'b0100, 4'b0001, 4'b0000, 4'b0000};
    localparam logic [2:0] CC [11] = '{COND_EQ, COND_NE, COND_NE, COND_LT, COND_LT, COND_GE,
                                       COND_GT, COND_GT, COND_LE, COND_LE, COND_NV};
    localparam logic       CP [11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                                       1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    alu_result_stage #(.WIDTH(32), .RW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_flags     (in_flags),
        .in_rd        (in_rd),
        .in_cond      (in_cond),
        .in_reg_write (in_reg_write),
        .in_flag_set  (in_flag_set),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_we       (out_we),
        .flags_q      (flags_q)
    );

    always #5 clk = ~clk;

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] r, input logic [3:0] f, input logic [3:0] d,
                        input logic [2:0] c, input logic we, input logic fs);
        in_valid     = 1'b1;
        in_result    = r;
        in_flags     = f;
        in_rd        = d;
        in_cond      = c;
        in_reg_write = we;
        in_flag_set  = fs;
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        in_flag_set  = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total_cnt++; if (flags_q !== 4'b0000) $display("FAIL rst_flags got=%b exp=0000", flags_q); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", in_ready); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rel_in_ready_pre got=%b exp=0", in_ready); else pass_cnt++;
        idle();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready_post got=%b exp=1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rel_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    endtask

    task automatic test_flag_eq();
        out_ready = 1'b1;
        send(32'h0, 4'b0100, 4'd0, COND_AL, 1'b0, 1'b1);
        total_cnt++; if (flags_q !== 4'b0100) $display("FAIL feq_flags got=%b exp=0100", flags_q); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b1 || out_we !== 1'b0) $display("FAIL feq_first got=%b/%b exp=1/0", out_valid, out_we); else pass_cnt++;
        send(32'h5, 4'b0000, 4'd3, COND_EQ, 1'b1, 1'b0);
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL feq_valid got=%b exp=1", out_valid); else pass_cnt++;
        total_cnt++; if (out_result !== 32'h5) $display("FAIL feq_result got=%h exp=5", out_result); else pass_cnt++;
        total_cnt++; if (out_rd !== 4'd3) $display("FAIL feq_rd got=%0d exp=3", out_rd); else pass_cnt++;
        total_cnt++; if (out_we !== 1'b1) $display("FAIL feq_we got=%b exp=1", out_we); else pass_cnt++;
        idle();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL feq_drain got=%b exp=0", out_valid); else pass_cnt++;
    endtask

    task automatic test_cond_fail();
        out_ready = 1'b1;
        send(32'h0, 4'b0000, 4'd0, COND_AL, 1'b0, 1'b1);
        idle();
        total_cnt++; if (flags_q !== 4'b0000) $display("FAIL cf_flags_pre got=%b exp=0000", flags_q); else pass_cnt++;
        send(32'h77, 4'b1000, 4'd1, COND_EQ, 1'b1, 1'b1);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL cf_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (flags_q !== 4'b0000) $display("FAIL cf_flags got=%b exp=0000", flags_q); else pass_cnt++;
        idle();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL cf_valid_late got=%b exp=0", out_valid); else pass_cnt++;
    endtask

    task automatic test_conditions();
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            send(32'h0, CF[i], 4'd0, COND_AL, 1'b0, 1'b1);
            send(32'(i + 100), 4'b0000, 4'(i), CC[i], 1'b1, 1'b0);
            total_cnt++;
            if (out_valid !== CP[i]) $display("FAIL cond_%0d valid got=%b exp=%b", i, out_valid, CP[i]);
            else pass_cnt++;
            if (CP[i]) begin
                total_cnt++;
                if (out_result !== 32'(i + 100)) $display("FAIL cond_%0d result got=%0d exp=%0d", i, out_result, i + 100);
                else pass_cnt++;
            end
            idle();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(32'h1, 4'b0000, 4'd1, COND_AL, 1'b1, 1'b0);
        send(32'h2, 4'b0000, 4'd2, COND_AL, 1'b1, 1'b0);
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready got=%b exp=0", in_ready); else pass_cnt++;
        total_cnt++; if (out_result !== 32'h1 || out_valid !== 1'b1) $display("FAIL bp_head got=%h/%b exp=1/1", out_result, out_valid); else pass_cnt++;
        idle();
        total_cnt++; if (out_result !== 32'h1 || out_rd !== 4'd1) $display("FAIL bp_stable got=%h/%0d exp=1/1", out_result, out_rd); else pass_cnt++;
        out_ready = 1'b1;
        idle();
        total_cnt++; if (out_result !== 32'h2 || out_valid !== 1'b1) $display("FAIL bp_second got=%h/%b exp=2/1", out_result, out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back got=%b exp=1", in_ready); else pass_cnt++;
        idle();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_empty got=%b exp=0", out_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send(32'd1, 4'b0000, 4'd1, COND_AL, 1'b1, 1'b0);
        total_cnt++; if (out_result !== 32'd1 || out_valid !== 1'b1) $display("FAIL b2b_1 got=%0d/%b exp=1/1", out_result, out_valid); else pass_cnt++;
        for (int k = 2; k <= 10; k++) begin
            send(32'(k), 4'b0000, 4'(k), COND_AL, 1'b1, 1'b0);
            total_cnt++;
            if (out_result !== 32'(k) || out_valid !== 1'b1 || in_ready !== 1'b1)
                $display("FAIL b2b_%0d got=%0d/%b/%b exp=%0d/1/1", k, out_result, out_valid, in_ready, k);
            else pass_cnt++;
        end
        idle();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got=%b exp=0", out_valid); else pass_cnt++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send(32'hA, 4'b1010, 4'd0, COND_AL, 1'b1, 1'b1);
        send(32'hB, 4'b0000, 4'd1, COND_AL, 1'b1, 1'b0);
        total_cnt++; if (flags_q !== 4'b1010 || in_ready !== 1'b0) $display("FAIL fl_pre got=%b/%b exp=1010/0", flags_q, in_ready); else pass_cnt++;
        flush = 1'b1;
        send(32'hF, 4'b0101, 4'd2, COND_AL, 1'b1, 1'b1);
        flush = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL fl_full_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (flags_q !== 4'b1010) $display("FAIL fl_full_flags got=%b exp=1010", flags_q); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL fl_full_ready got=%b exp=1", in_ready); else pass_cnt++;
        send(32'hC, 4'b0000, 4'd3, COND_AL, 1'b1, 1'b0);
        flush = 1'b1;
        send(32'hD, 4'b0101, 4'd4, COND_AL, 1'b1, 1'b1);
        flush = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL fl_acc_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (flags_q !== 4'b1010) $display("FAIL fl_acc_flags got=%b exp=1010", flags_q); else pass_cnt++;
        idle();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL fl_late_valid got=%b exp=0", out_valid); else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        send(32'hE, 4'b1111, 4'd2, COND_AL, 1'b1, 1'b1);
        total_cnt++; if (flags_q !== 4'b1111 || out_valid !== 1'b1) $display("FAIL rm_pre got=%b/%b exp=1111/1", flags_q, out_valid); else pass_cnt++;
        #3;
        rst          = 1'b1;
        in_valid     = 1'b1;
        in_flag_set  = 1'b1;
        in_flags     = 4'b0011;
        in_cond      = COND_AL;
        #1;
        total_cnt++; if (flags_q !== 4'b0000) $display("FAIL rm_flags got=%b exp=0000", flags_q); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rm_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rm_ready got=%b exp=0", in_ready); else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rm_rel_ready_pre got=%b exp=0", in_ready); else pass_cnt++;
        idle();
        in_valid    = 1'b0;
        in_flag_set = 1'b0;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rm_rel_ready got=%b exp=1", in_ready); else pass_cnt++;
        total_cnt++; if (flags_q !== 4'b0000 || out_valid !== 1'b0) $display("FAIL rm_lost got=%b/%b exp=0000/0", flags_q, out_valid); else pass_cnt++;
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_result    = '0;
        in_flags     = '0;
        in_rd        = '0;
        in_cond      = COND_AL;
        in_reg_write = 1'b0;
        in_flag_set  = 1'b0;
        flush        = 1'b0;
        out_ready    = 1'b0;

        test_reset();
        test_flag_eq();
        test_cond_fail();
        test_conditions();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_midflight();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
